// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control slice: FSM state encoding and its width.
package stopwatch_pkg;

  localparam int SW_STATE_W = 2;

  typedef enum logic [SW_STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Button front end: 2-FF synchroniser, previous-value register and rising-edge detect.
// All stages reset to 1 so a button held through reset release yields no event.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button events drive an IDLE/RUN/LAP/STOP FSM; a prescaler
// produces the count-enable tick while running and is cleared on STOP -> IDLE.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int unsigned DIV = 500000,
  localparam int unsigned CW  = $clog2(DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_ss_i,
  input  logic                  btn_lap_i,
  input  logic                  btn_clr_i,
  output logic                  tick_o,
  output logic                  clr_o,
  output logic                  disp_live_o,
  output logic                  running_o,
  output logic [SW_STATE_W-1:0] state_o
);

  localparam logic [CW-1:0] PRESC_MAX = CW'(DIV - 1);

  logic      ss_ev;
  logic      lap_ev;
  logic      clr_ev;
  sw_state_t state_q, state_d;
  logic      clr_q, clr_d;
  logic [CW-1:0] presc_q, presc_d;
  logic      running;

  btn_edge_sync u_sync_ss  (.clk(clk), .reset(reset), .btn_i(btn_ss_i),  .rise_o(ss_ev));
  btn_edge_sync u_sync_lap (.clk(clk), .reset(reset), .btn_i(btn_lap_i), .rise_o(lap_ev));
  btn_edge_sync u_sync_clr (.clk(clk), .reset(reset), .btn_i(btn_clr_i), .rise_o(clr_ev));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      presc_q <= presc_d;
    end
  end

  assign running = (state_q == RUN) || (state_q == LAP);

  // Only events legal in the current state are considered; among those clr > ss > lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_ev) state_d = RUN;
      end
      RUN: begin
        if (ss_ev)       state_d = STOP;
        else if (lap_ev) state_d = LAP;
      end
      LAP: begin
        if (ss_ev)       state_d = STOP;
        else if (lap_ev) state_d = RUN;
      end
      STOP: begin
        if (clr_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (ss_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler holds in STOP so a paused interval resumes where it left off.
  always_comb begin
    presc_d = presc_q;
    if (clr_d) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + CW'(1);
    end
  end

  assign tick_o      = running && (presc_q == PRESC_MAX);
  assign clr_o       = clr_q;
  assign running_o   = running;
  assign disp_live_o = (state_q != LAP);
  assign state_o     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV = 4: directed scenarios plus random button
// traffic, checked against a cycle-level reference model of the stopwatch rules.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss_i = 1'b0;
  logic       btn_lap_i = 1'b0;
  logic       btn_clr_i = 1'b0;
  logic       tick_o;
  logic       clr_o;
  logic       disp_live_o;
  logic       running_o;
  logic [1:0] state_o;
  logic [5:0] dut_vec;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_ss_i    (btn_ss_i),
    .btn_lap_i   (btn_lap_i),
    .btn_clr_i   (btn_clr_i),
    .tick_o      (tick_o),
    .clr_o       (clr_o),
    .disp_live_o (disp_live_o),
    .running_o   (running_o),
    .state_o     (state_o)
  );

  assign dut_vec = {state_o, tick_o, clr_o, disp_live_o, running_o};

  // Reference model: states 0 IDLE, 1 RUN, 2 LAP, 3 STOP. m_elapsed counts running
  // cycles since the last clear; a tick falls on every DIV-th running cycle.
  int       m_state;
  int       m_elapsed;
  bit       m_clr;
  bit [2:0] h_ss, h_lap, h_clr;
  bit       e_ss, e_lap, e_clr;
  int       m_next;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state   = 0;
      m_elapsed = 0;
      m_clr     = 0;
      h_ss      = 3'b111;
      h_lap     = 3'b111;
      h_clr     = 3'b111;
    end else begin
      // Sample history: bit0 newest. A press is seen two samples late, as a 0->1 step.
      e_ss  = h_ss[1]  & ~h_ss[2];
      e_lap = h_lap[1] & ~h_lap[2];
      e_clr = h_clr[1] & ~h_clr[2];
      m_next = m_state;
      m_clr  = 0;
      case (m_state)
        0: if (e_ss) m_next = 1;
        1: if (e_ss) m_next = 3; else if (e_lap) m_next = 2;
        2: if (e_ss) m_next = 3; else if (e_lap) m_next = 1;
        default: if (e_clr) begin m_next = 0; m_clr = 1; end else if (e_ss) m_next = 1;
      endcase
      if (m_state == 1 || m_state == 2) m_elapsed = m_elapsed + 1;
      if (m_clr) m_elapsed = 0;
      m_state = m_next;
      h_ss  = {h_ss[1:0],  btn_ss_i};
      h_lap = {h_lap[1:0], btn_lap_i};
      h_clr = {h_clr[1:0], btn_clr_i};
    end
  end

  function automatic logic [5:0] exp_vec();
    logic run;
    run = (m_state == 1) || (m_state == 2);
    return {2'(m_state), run && ((m_elapsed % DIV) == DIV - 1), m_clr, m_state != 2, run};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    btn_ss_i = 0; btn_lap_i = 0; btn_clr_i = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 6'b000010) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", i, dut_vec, 6'b000010);
      end
    end
  endtask

  task automatic test_start();
    int ticks = 0;
    int rel = $urandom_range(3, 10);
    btn_ss_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (state_o !== 2'd0) begin
        n_fail++; $display("FAIL start_latency_early: got %0d want 0", state_o);
      end
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (state_o !== 2'd1) begin
          n_fail++; $display("FAIL start_third_edge: got %0d want 1", state_o);
        end
      end
      n_checks++;
      if (tick_o !== ((i % DIV) == 0)) begin
        n_fail++; $display("FAIL start_tick cycle %0d: got %b want %b", i, tick_o, (i % DIV) == 0);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL start_model cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (tick_o === 1'b1) ticks++;
      if (i == rel) btn_ss_i = 1'b0;
    end
    n_checks++;
    if (ticks != 10) begin
      n_fail++; $display("FAIL start_tick_count: got %0d want 10", ticks);
    end
  endtask

  task automatic test_lap();
    int ticks = 0;
    int rel1 = $urandom_range(3, 8);
    int rel2 = 20 + $urandom_range(3, 8);
    btn_lap_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2 || i == 3 || i == 22 || i == 23) begin
        n_checks++;
        if (disp_live_o !== (i == 2 || i == 23)) begin
          n_fail++; $display("FAIL lap_disp cycle %0d: got %b want %b", i, disp_live_o, i == 2 || i == 23);
        end
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL lap_model cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (tick_o === 1'b1) ticks++;
      if (i == rel1 || i == rel2) btn_lap_i = 1'b0;
      if (i == 20) btn_lap_i = 1'b1;
    end
    n_checks++;
    if (ticks != 40 / DIV) begin
      n_fail++; $display("FAIL lap_tick_count: got %0d want %0d", ticks, 40 / DIV);
    end
  endtask

  task automatic test_stop_resume();
    bit found = 0;
    // Align so the prescaler holds 2 once STOP is entered.
    for (int k = 0; k < 20 && !found; k++) begin
      if ((m_state == 1) && ((m_elapsed % DIV) == DIV - 1)) found = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL stop_align: got no aligned RUN cycle want one within 20 cycles");
    end
    btn_ss_i = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        n_checks++;
        if (state_o !== 2'd3 || tick_o !== 1'b0) begin
          n_fail++; $display("FAIL stop_hold cycle %0d: got state %0d tick %b want state 3 tick 0", i, state_o, tick_o);
        end
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stop_model cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 5) btn_ss_i = 1'b0;
    end
    btn_ss_i = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 3 || j == 4) begin
        n_checks++;
        if (state_o !== 2'd1 || tick_o !== (j == 4)) begin
          n_fail++; $display("FAIL resume_tick cycle %0d: got state %0d tick %b want state 1 tick %b", j, state_o, tick_o, j == 4);
        end
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL resume_model cycle %0d: got %b want %b", j, dut_vec, exp_vec());
      end
      if (j == 5) btn_ss_i = 1'b0;
    end
  endtask

  task automatic test_clr_lap();
    int clr_pulses = 0;
    bit saw_lap = 0;
    btn_ss_i = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 9) begin
        n_checks++;
        if (state_o !== 2'd0 || clr_o !== 1'b1) begin
          n_fail++; $display("FAIL clr_to_idle: got state %0d clr %b want state 0 clr 1", state_o, clr_o);
        end
      end
      if (i >= 23) begin
        n_checks++;
        if (state_o !== 2'd1 || clr_o !== 1'b0) begin
          n_fail++; $display("FAIL clr_in_run cycle %0d: got state %0d clr %b want state 1 clr 0", i, state_o, clr_o);
        end
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL clr_model cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i <= 13 && clr_o === 1'b1) clr_pulses++;
      if (i <= 13 && state_o === 2'd2) saw_lap = 1;
      case (i)
        4:  btn_ss_i = 1'b0;
        6:  begin btn_clr_i = 1'b1; btn_lap_i = 1'b1; end
        12: begin btn_clr_i = 1'b0; btn_lap_i = 1'b0; end
        14: btn_ss_i = 1'b1;
        16: btn_ss_i = 1'b0;
        20: btn_clr_i = 1'b1;
        24: btn_clr_i = 1'b0;
        default: ;
      endcase
    end
    n_checks++;
    if (clr_pulses != 1 || saw_lap) begin
      n_fail++; $display("FAIL clr_pulse_count: got %0d pulses lap %b want 1 pulses lap 0", clr_pulses, saw_lap);
    end
  endtask

  task automatic test_reset_mid();
    btn_lap_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL midreset_pre cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 4) btn_lap_i = 1'b0;
    end
    n_checks++;
    if (state_o !== 2'd2) begin
      n_fail++; $display("FAIL midreset_in_lap: got %0d want 2", state_o);
    end
    btn_ss_i = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 6'b000010) begin
      n_fail++; $display("FAIL midreset_immediate: got %b want %b", dut_vec, 6'b000010);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 6'b000010) begin
        n_fail++; $display("FAIL midreset_no_run cycle %0d: got %b want %b", i, dut_vec, 6'b000010);
      end
      if (i == 10) btn_ss_i = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_model cycle %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if ($urandom_range(0, 5) == 0) btn_ss_i  = ~btn_ss_i;
      if ($urandom_range(0, 7) == 0) btn_lap_i = ~btn_lap_i;
      if ($urandom_range(0, 6) == 0) btn_clr_i = ~btn_clr_i;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_stop_resume();
    test_clr_lap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
